ysyx_220066_mc_seq: RTL and testbench

- Multi-cycle sequencer for the ysyx_220066 RV64 core.
- Replaces single-cycle timing (fetch, decode, execute and write-back all in one clock) with an FSM.
- Owns the PC and the latched instruction. Drives valid/ready handshakes to separate instruction and data buses with variable latency.
- Gates register-file and CSR write enables to one write-back cycle per instruction. Reports sticky error/done status and a retired-instruction count.

---
 rtl/ysyx_220066_mc_seq.sv | 106 ++++++++++
 tb/tb_ysyx_220066_mc_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_mc_seq.sv
// ysyx_220066_mc_seq: multi-cycle fetch/exec/mem/write-back sequencer with bus handshakes and watchdog
module ysyx_220066_mc_seq #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_data,
  input  logic            dec_memrd,
  input  logic            dec_memwr,
  input  logic            dec_regwr,
  input  logic            dec_csrwen,
  input  logic            dec_error,
  input  logic            dec_done,
  input  logic [XLEN-1:0] ex_nxtpc,
  input  logic            trap_jmp,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] ld_data,
  output logic            rf_wen,
  output logic            csr_wen,
  output logic            commit,
  output logic [XLEN-1:0] instret,
  output logic            error,
  output logic [1:0]      err_code,
  output logic            done
);
  typedef enum logic [2:0] {IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT} state_t;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t state, nxt;
  logic [TIMEOUT_W-1:0] wd;
  logic progress, fetch_st, wait_st, timeout;
  // handshake outputs decode only from registered state and are squashed during reset
  always_comb begin
    imem_req_valid = !rst && state == IF_REQ;
    dmem_req_valid = !rst && state == MEM_REQ;
    dmem_we        = !rst && state == MEM_REQ && dec_memwr;
    rf_wen         = !rst && state == WB && dec_regwr;
    csr_wen        = !rst && state == WB && dec_csrwen;
    commit         = !rst && state == WB;
    imem_addr      = pc;
  end
  // next state; a stall reaching its last allowed cycle without progress times out to HALT
  always_comb begin
    fetch_st = state == IF_REQ || state == IF_WAIT;
    wait_st  = fetch_st || state == MEM_REQ || state == MEM_WAIT;
    progress = state == IF_REQ  ? imem_req_ready :
               state == IF_WAIT ? imem_resp_valid :
               state == MEM_REQ ? dmem_req_ready : dmem_resp_valid;
    timeout  = wait_st && !progress && wd == WD_LAST;
    nxt = state;
    case (state)
      IF_REQ:   nxt = imem_req_ready ? IF_WAIT : IF_REQ;
      IF_WAIT:  nxt = imem_resp_valid ? EXEC : IF_WAIT;
      EXEC:     nxt = dec_error ? HALT : (dec_memrd || dec_memwr) ? MEM_REQ : WB;
      MEM_REQ:  nxt = dmem_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: nxt = dmem_resp_valid ? WB : MEM_WAIT;
      WB:       nxt = dec_done ? HALT : IF_REQ;
      default:  nxt = HALT;
    endcase
    if (timeout) nxt = HALT;
  end
  // architectural state, latches, counters and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IF_REQ;
      pc       <= RESET_PC;
      instr    <= '0;
      ld_data  <= '0;
      instret  <= '0;
      error    <= 1'b0;
      err_code <= 2'd0;
      done     <= 1'b0;
      wd       <= '0;
    end else begin
      state <= nxt;
      wd    <= (nxt != state) ? '0 : wait_st ? wd + 1'b1 : wd;
      if (state == IF_WAIT && imem_resp_valid) instr <= imem_resp_data;
      if (state == MEM_WAIT && dmem_resp_valid && !dec_memwr) ld_data <= dmem_resp_data;
      if (state == WB) begin
        pc      <= trap_jmp ? trap_pc : ex_nxtpc;
        instret <= instret + 1'b1;
        if (dec_done) done <= 1'b1;
      end
      if (state == EXEC && dec_error) begin
        error    <= 1'b1;
        err_code <= 2'd1;
      end
      if (timeout) begin
        error    <= 1'b1;
        err_code <= fetch_st ? 2'd2 : 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_220066_mc_seq.sv
// tb_ysyx_220066_mc_seq: randomized transaction-level check of the multi-cycle sequencer
module tb_ysyx_220066_mc_seq;
  localparam int TW = 4;
  localparam int TO = (1 << TW) - 1;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_addr;
  logic [31:0] imem_resp_data;
  logic dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
  logic [63:0] dmem_resp_data;
  logic dec_memrd, dec_memwr, dec_regwr, dec_csrwen, dec_error, dec_done, trap_jmp;
  logic [63:0] ex_nxtpc, trap_pc, pc, ld_data, instret;
  logic [31:0] instr;
  logic rf_wen, csr_wen, commit, error, done;
  logic [1:0] err_code;
  int errs = 0, checks = 0;
  logic [63:0] m_pc, m_instret, m_ld;

  ysyx_220066_mc_seq #(.XLEN(64), .RESET_PC(RPC), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .dec_memrd(dec_memrd), .dec_memwr(dec_memwr), .dec_regwr(dec_regwr), .dec_csrwen(dec_csrwen),
    .dec_error(dec_error), .dec_done(dec_done), .ex_nxtpc(ex_nxtpc), .trap_jmp(trap_jmp),
    .trap_pc(trap_pc), .pc(pc), .instr(instr), .ld_data(ld_data), .rf_wen(rf_wen),
    .csr_wen(csr_wen), .commit(commit), .instret(instret), .error(error),
    .err_code(err_code), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic quiet;
    {imem_req_ready, imem_resp_valid, dmem_req_ready, dmem_resp_valid} = '0;
    {dec_memrd, dec_memwr, dec_regwr, dec_csrwen, dec_error, dec_done, trap_jmp} = '0;
    imem_resp_data = '0;
    dmem_resp_data = '0;
    ex_nxtpc = '0;
    trap_pc = '0;
  endtask

  task automatic do_reset;
    rst = 1;
    quiet();
    @(posedge clk);
    #1;
    chk("rst_ireq", imem_req_valid, 0);
    chk("rst_dreq", dmem_req_valid, 0);
    chk("rst_commit", commit, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_instret", instret, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ld", ld_data, 0);
    chk("rst_err", {error, err_code}, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 0;
    #1;
    m_pc = RPC;
    m_instret = 0;
    m_ld = 0;
  endtask

  task automatic expect_halt(input logic [1:0] code);
    imem_req_ready = 1;
    dmem_req_ready = 1;
    repeat (4) begin
      chk("halt_ireq", imem_req_valid, 0);
      chk("halt_dreq", dmem_req_valid, 0);
      chk("halt_commit", commit, 0);
      chk("halt_wen", {rf_wen, csr_wen}, 0);
      chk("halt_error", error, code != 0);
      chk("halt_code", err_code, code);
      chk("halt_done", done, code == 0);
      chk("halt_pc", pc, m_pc);
      chk("halt_instret", instret, m_instret);
      tick();
    end
    imem_req_ready = 0;
    dmem_req_ready = 0;
  endtask

  // one instruction; a delay >= TO means the bus never answers in that phase
  task automatic run_instr(input int a, b, c, d, kind, input bit regwr, csrwen, err, dn, trap, abort);
    logic [31:0] word;
    logic [63:0] nxt, tpc, ldv;
    word = $urandom;
    nxt = ($urandom_range(3) == 0) ? {$urandom, $urandom} : m_pc + 4;
    tpc = {$urandom, $urandom};
    ldv = {$urandom, $urandom};
    dec_memrd = kind == 1;
    dec_memwr = kind == 2;
    dec_regwr = regwr;
    dec_csrwen = csrwen;
    dec_error = err;
    dec_done = dn;
    trap_jmp = trap;
    ex_nxtpc = nxt;
    trap_pc = tpc;
    chk("start_pc", pc, m_pc);
    chk("start_instret", instret, m_instret);
    for (int k = 0; k < TO; k++) begin
      chk("if_ireq", imem_req_valid, 1);
      chk("if_addr", imem_addr, m_pc);
      chk("if_dreq", dmem_req_valid, 0);
      chk("if_commit", commit, 0);
      imem_req_ready = (k == a);
      tick();
      imem_req_ready = 0;
      if (k == a) break;
    end
    if (a >= TO) begin expect_halt(2); return; end
    for (int k = 0; k < TO; k++) begin
      chk("iw_ireq", imem_req_valid, 0);
      chk("iw_commit", commit, 0);
      imem_resp_valid = (k == b);
      imem_resp_data = word;
      tick();
      imem_resp_valid = 0;
      if (k == b) break;
    end
    if (b >= TO) begin expect_halt(2); return; end
    chk("ex_instr", instr, word);
    chk("ex_req", {imem_req_valid, dmem_req_valid}, 0);
    chk("ex_wen", {rf_wen, csr_wen, commit}, 0);
    tick();
    if (err) begin expect_halt(1); return; end
    if (kind != 0) begin
      for (int k = 0; k < TO; k++) begin
        chk("mr_dreq", dmem_req_valid, 1);
        chk("mr_we", dmem_we, kind == 2);
        chk("mr_ireq", imem_req_valid, 0);
        dmem_req_ready = (k == c);
        tick();
        dmem_req_ready = 0;
        if (k == c) break;
      end
      if (c >= TO) begin expect_halt(3); return; end
      for (int k = 0; k < TO; k++) begin
        chk("mw_dreq", dmem_req_valid, 0);
        chk("mw_commit", commit, 0);
        if (abort && k == 2) begin do_reset(); return; end
        dmem_resp_valid = (k == d);
        dmem_resp_data = ldv;
        tick();
        dmem_resp_valid = 0;
        if (k == d) break;
      end
      if (d >= TO) begin expect_halt(3); return; end
      if (kind == 1) m_ld = ldv;
    end
    chk("wb_rf", rf_wen, regwr);
    chk("wb_csr", csr_wen, csrwen);
    chk("wb_commit", commit, 1);
    chk("wb_ld", ld_data, m_ld);
    chk("wb_req", {imem_req_valid, dmem_req_valid}, 0);
    chk("wb_status", {error, done}, 0);
    tick();
    m_pc = trap ? tpc : nxt;
    m_instret++;
    if (dn) expect_halt(0);
  endtask

  function automatic int rdly();
    return ($urandom_range(11) == 0) ? TO - 1 : int'($urandom_range(4));
  endfunction

  initial begin
    quiet();
    do_reset();
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_instr(0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    run_instr(1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    run_instr(TO - 1, TO - 1, TO - 1, TO - 1, 1, 1, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(TO, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(0, TO, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(0, 0, TO, 0, 1, 1, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(0, 0, 0, TO, 2, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    do_reset();
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    do_reset();
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1);
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      int kind;
      bit err, dn;
      kind = $urandom_range(2);
      err = $urandom_range(24) == 0;
      dn = $urandom_range(24) == 0;
      run_instr(rdly(), rdly(), rdly(), rdly(), kind, 1'($urandom), 1'($urandom), err, dn,
                $urandom_range(7) == 0, 0);
      if (err || dn) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
